// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment reader: decoder patterns (a = bit 6),
// special output codes and FSM state encodings.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational inverse of the BCD-to-7-segment decoder: pattern to 4-bit code.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code
);

  always_comb begin
    o_code = CODE_ERR;
    case (i_seg)
      SEG_0:     o_code = 4'd0;
      SEG_1:     o_code = 4'd1;
      SEG_2:     o_code = 4'd2;
      SEG_3:     o_code = 4'd3;
      SEG_4:     o_code = 4'd4;
      SEG_5:     o_code = 4'd5;
      SEG_6:     o_code = 4'd6;
      SEG_7:     o_code = 4'd7;
      SEG_8:     o_code = 4'd8;
      SEG_9:     o_code = 4'd9;
      SEG_BLANK: o_code = CODE_BLANK;
      default:   o_code = CODE_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples a multiplexed 7-segment bus, debounces each strobe period and
// assembles a full frame of digit codes presented over valid/ready.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [6:0]              i_seg,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  output logic [4*NUM_DIGITS-1:0] o_out_digits,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_out_err,
  output logic                    o_overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]              r_seg, r_seg_prev;
  logic [NUM_DIGITS-1:0]   r_den, r_den_prev;
  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [4*NUM_DIGITS-1:0] r_slots;
  logic [4*NUM_DIGITS-1:0] r_out_digits;
  logic                    r_out_valid;
  logic                    r_out_err;
  logic                    r_overrun;

  state_t                  w_state_nxt;
  logic [CW-1:0]           w_cnt_nxt;
  logic                    w_capture;
  logic                    w_onehot;
  logic                    w_changed;
  logic [IW-1:0]           w_idx;
  logic [3:0]              w_code;
  logic [NUM_DIGITS-1:0]   w_cap_bit;
  logic [NUM_DIGITS-1:0]   w_mask_nxt;
  logic [4*NUM_DIGITS-1:0] w_slots_nxt;
  logic                    w_complete;
  logic                    w_load;
  logic                    w_discard;
  logic                    w_frame_err;

  seg7_encode u_encode (
    .i_seg  (r_seg),
    .o_code (w_code)
  );

  assign w_onehot  = (r_den != '0) && ((r_den & (r_den - 1'b1)) == '0);
  assign w_changed = {r_seg, r_den} != {r_seg_prev, r_den_prev};

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_den[i]) w_idx = IW'(i);
    end
  end

  // Capture fires on the cycle the match count reaches STABLE_CYCLES.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_WAIT: begin
        w_cnt_nxt = '0;
        if (w_onehot) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_SETTLE: begin
        if (!w_onehot) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else if (w_changed) begin
          w_cnt_nxt = CW'(1);
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (!w_onehot) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else if (w_changed) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
    endcase
    if (w_state_nxt == S_SETTLE && w_cnt_nxt == CNT_MAX) begin
      w_capture   = 1'b1;
      w_state_nxt = S_HOLD;
    end
  end

  always_comb begin
    w_cap_bit   = '0;
    w_slots_nxt = r_slots;
    if (w_capture) begin
      w_cap_bit[w_idx] = 1'b1;
      w_slots_nxt[4*w_idx +: 4] = w_code;
    end
  end

  // A full mask is consumed one cycle after the last capture, so the
  // presented frame always comes from the slot registers.
  assign w_complete = &r_mask;
  assign w_load     = w_complete && (!r_out_valid || i_out_ready);
  assign w_discard  = w_complete && r_out_valid && !i_out_ready;
  assign w_mask_nxt = (w_complete ? '0 : r_mask) | w_cap_bit;

  always_comb begin
    w_frame_err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_slots[4*i +: 4] == CODE_ERR) w_frame_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg        <= '0;
      r_den        <= '0;
      r_seg_prev   <= '0;
      r_den_prev   <= '0;
      r_state      <= S_WAIT;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_slots      <= '0;
      r_out_digits <= '0;
      r_out_valid  <= 1'b0;
      r_out_err    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_seg      <= i_seg;
      r_den      <= i_digit_en;
      r_seg_prev <= r_seg;
      r_den_prev <= r_den;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mask     <= w_mask_nxt;
      r_slots    <= w_slots_nxt;
      r_overrun  <= w_discard;
      if (w_load) begin
        r_out_digits <= r_slots;
        r_out_valid  <= 1'b1;
        r_out_err    <= w_frame_err;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_digits = r_out_digits;
  assign o_out_valid  = r_out_valid;
  assign o_out_err    = r_out_err;
  assign o_overrun    = r_overrun;

endmodule
